// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: MEM/WB writes always win, long-latency results wait in a FIFO.
// Optional feature macro WAW_SQUASH_EN: a pipeline write kills older queued writes to the same register.
module regfile_wr_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_we,
    input  logic [ADDR_W-1:0]      wb_waddr,
    input  logic [DATA_W-1:0]      wb_wdata,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [ADDR_W-1:0]      lu_waddr,
    input  logic [DATA_W-1:0]      lu_wdata,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    output logic                   stall_req,
    output logic [(2**ADDR_W)-1:0] pend_mask,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_killed;
    logic [DEPTH-1:0]  entry_vld;
    logic [DEPTH-1:0]  entry_live;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v >= WAIT_W'(MAX_WAIT)) return v;
        return v + WAIT_W'(1);
    endfunction

    // A slot is occupied when its distance from the read pointer is below the fill level.
    function automatic logic slot_busy(input logic [PTR_W-1:0] slot,
                                       input logic [PTR_W-1:0] rd,
                                       input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] off;
        off = slot - rd;
        return {1'b0, off} < cnt;
    endfunction

    assign empty    = (count == '0);
    assign lu_ready = !rst && (count < CNT_W'(DEPTH));
    assign push     = lu_valid && lu_ready && (lu_waddr != '0);
    assign pop      = !rst && !empty && (!wb_we || head_killed);
    assign wait_inc = sat_inc(wait_cnt);
    assign q_count  = rst ? '0 : count;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_vld[i] = slot_busy(PTR_W'(i), rd_ptr, count);
        end
    end

`ifdef WAW_SQUASH_EN
    logic [DEPTH-1:0] killed;

    assign head_killed = killed[rd_ptr];
    assign entry_live  = entry_vld & ~killed;

    // The pipeline write is newer than anything already queued for the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            killed <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_we && (wb_waddr != '0) && entry_vld[i] && (addr_q[i] == wb_waddr))
                    killed[i] <= 1'b1;
            end
            if (push) killed[wr_ptr] <= 1'b0;
        end
    end
`else
    assign head_killed = 1'b0;
    assign entry_live  = entry_vld;
`endif

    always_comb begin
        pend_mask = '0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_live[i]) pend_mask[addr_q[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!rst) begin
            if (wb_we) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (pop && !head_killed) begin
                rf_we    = 1'b1;
                rf_waddr = addr_q[rd_ptr];
                rf_wdata = data_q[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= lu_waddr;
            data_q[wr_ptr] <= lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            wait_cnt  <= '0;
            stall_req <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);

            // Starvation: the head's wait age, stall held until the cycle after it pops.
            if (pop || empty) wait_cnt <= '0;
            else              wait_cnt <= wait_inc;

            if (pop)
                stall_req <= 1'b0;
            else if (!empty && (wait_inc >= WAIT_W'(MAX_WAIT)))
                stall_req <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed vector table, corner sequences, random vs queue model.
module tb_regfile_wr_arbiter;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;
    localparam int AW       = 5;
    localparam int DW       = 32;

    logic          clk;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_waddr;
    logic [DW-1:0] lu_wdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          stall_req;
    logic [31:0]   pend_mask;
    logic [2:0]    q_count;

    regfile_wr_arbiter #(
        .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .pend_mask(pend_mask), .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: pending writes as a plain queue in acceptance order.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            killed;
    } ent_t;

    ent_t m_q[$];
    int   m_wait;
    bit   m_stall;

    logic          e_we;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_ready;
    logic [2:0]    e_q;
    logic          e_stall;
    logic [31:0]   e_pend;

    function automatic void model_eval();
        bit head_pop;
        e_stall = m_stall;
        e_we    = 1'b0;
        e_waddr = '0;
        e_wdata = '0;
        e_ready = 1'b0;
        e_q     = '0;
        e_pend  = '0;
        if (rst) return;
        e_ready = (m_q.size() < DEPTH);
        e_q     = 3'(m_q.size());
        foreach (m_q[i]) if (!m_q[i].killed) e_pend[m_q[i].addr] = 1'b1;
        e_pend[0] = 1'b0;
        head_pop = (m_q.size() > 0) && (!wb_we || m_q[0].killed);
        if (wb_we) begin
            e_we = 1'b1; e_waddr = wb_waddr; e_wdata = wb_wdata;
        end else if (head_pop && !m_q[0].killed) begin
            e_we = 1'b1; e_waddr = m_q[0].addr; e_wdata = m_q[0].data;
        end
    endfunction

    function automatic void model_advance();
        bit   popped;
        int   n_before;
        ent_t e;
        if (rst) begin
            m_q.delete();
            m_wait  = 0;
            m_stall = 0;
            return;
        end
        n_before = m_q.size();
        popped   = (n_before > 0) && (!wb_we || m_q[0].killed);
`ifdef WAW_SQUASH_EN
        if (wb_we && wb_waddr != '0)
            foreach (m_q[i]) if (m_q[i].addr == wb_waddr) m_q[i].killed = 1'b1;
`endif
        if (popped) void'(m_q.pop_front());
        if (lu_valid && n_before < DEPTH && lu_waddr != '0) begin
            e.addr = lu_waddr; e.data = lu_wdata; e.killed = 1'b0;
            m_q.push_back(e);
        end
        if (popped) begin
            m_wait = 0; m_stall = 0;
        end else if (n_before > 0) begin
            m_wait++;
            if (m_wait >= MAX_WAIT) m_stall = 1;
        end else begin
            m_wait = 0;
        end
    endfunction

    function automatic void check_model(input string tag);
        model_eval();
        chk({tag, ".rf_we"},     64'(rf_we),     64'(e_we));
        chk({tag, ".rf_waddr"},  64'(rf_waddr),  64'(e_waddr));
        chk({tag, ".rf_wdata"},  64'(rf_wdata),  64'(e_wdata));
        chk({tag, ".lu_ready"},  64'(lu_ready),  64'(e_ready));
        chk({tag, ".q_count"},   64'(q_count),   64'(e_q));
        chk({tag, ".stall_req"}, 64'(stall_req), 64'(e_stall));
        chk({tag, ".pend_mask"}, 64'(pend_mask), 64'(e_pend));
    endfunction

    task automatic step(input string tag);
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        rst = r; wb_we = we; wb_waddr = wa; wb_wdata = wd;
        lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    endtask

    typedef struct {
        logic          rst;
        logic          wb_we;
        logic [AW-1:0] wb_waddr;
        logic [DW-1:0] wb_wdata;
        logic          lu_valid;
        logic [AW-1:0] lu_waddr;
        logic [DW-1:0] lu_wdata;
        logic          x_we;
        logic [AW-1:0] x_waddr;
        logic [DW-1:0] x_wdata;
        logic          x_ready;
        logic [2:0]    x_q;
        logic          x_stall;
        logic [31:0]   x_pend;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic r, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                                input logic xwe, input logic [AW-1:0] xwa, input logic [DW-1:0] xwd,
                                input logic xr, input logic [2:0] xq, input logic xs, input logic [31:0] xp);
        vec_t v;
        v.rst = r; v.wb_we = we; v.wb_waddr = wa; v.wb_wdata = wd;
        v.lu_valid = lv; v.lu_waddr = la; v.lu_wdata = ld;
        v.x_we = xwe; v.x_waddr = xwa; v.x_wdata = xwd;
        v.x_ready = xr; v.x_q = xq; v.x_stall = xs; v.x_pend = xp;
        return v;
    endfunction

    logic [AW-1:0] got[$];
    logic [DW-1:0] last5;
    int            wb_pct;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_wait = 0;
        m_stall = 0;
        //             rst   we    waddr  wdata          lv    laddr  ldata          xwe   xwa    xwd            xrdy  xq    xst   xpend
        tbl[0]  = mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 3'd0, 1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 1'b1, 5'd3,  32'hA5A5A5A5,  1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  32'hA5A5A5A5,  1'b1, 3'd0, 1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h12345678,  1'b0, 5'd0,  32'h0,         1'b1, 3'd0, 1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h12345678,  1'b1, 3'd1, 1'b0, 32'h80);
        tbl[4]  = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 3'd0, 1'b0, 32'h0);
        tbl[5]  = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'hDEADBEEF,  1'b0, 5'd0,  32'h0,         1'b1, 3'd0, 1'b0, 32'h0);
        tbl[6]  = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 3'd0, 1'b0, 32'h0);
        tbl[7]  = mk(1'b0, 1'b1, 5'd0,  32'h11,        1'b1, 5'd9,  32'h99,        1'b1, 5'd0,  32'h11,        1'b1, 3'd0, 1'b0, 32'h0);
        tbl[8]  = mk(1'b0, 1'b1, 5'd4,  32'h44,        1'b1, 5'd10, 32'hAA,        1'b1, 5'd4,  32'h44,        1'b1, 3'd1, 1'b0, 32'h200);
        tbl[9]  = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  32'h99,        1'b1, 3'd2, 1'b0, 32'h600);
        tbl[10] = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 32'hAA,        1'b1, 3'd1, 1'b0, 32'h400);
        tbl[11] = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 3'd0, 1'b0, 32'h0);
        tbl[12] = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 32'hC,         1'b0, 5'd0,  32'h0,         1'b1, 3'd0, 1'b0, 32'h0);
        tbl[13] = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd13, 32'hD,         1'b1, 5'd12, 32'hC,         1'b1, 3'd1, 1'b0, 32'h1000);
        tbl[14] = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd13, 32'hD,         1'b1, 3'd1, 1'b0, 32'h2000);
        tbl[15] = mk(1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 3'd0, 1'b0, 32'h0);

        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].wb_we, tbl[i].wb_waddr, tbl[i].wb_wdata,
                  tbl[i].lu_valid, tbl[i].lu_waddr, tbl[i].lu_wdata);
            @(negedge clk);
            chk($sformatf("vec%0d.rf_we", i),     64'(rf_we),     64'(tbl[i].x_we));
            chk($sformatf("vec%0d.rf_waddr", i),  64'(rf_waddr),  64'(tbl[i].x_waddr));
            chk($sformatf("vec%0d.rf_wdata", i),  64'(rf_wdata),  64'(tbl[i].x_wdata));
            chk($sformatf("vec%0d.lu_ready", i),  64'(lu_ready),  64'(tbl[i].x_ready));
            chk($sformatf("vec%0d.q_count", i),   64'(q_count),   64'(tbl[i].x_q));
            chk($sformatf("vec%0d.stall_req", i), 64'(stall_req), 64'(tbl[i].x_stall));
            chk($sformatf("vec%0d.pend_mask", i), 64'(pend_mask), 64'(tbl[i].x_pend));
            @(posedge clk);
            model_advance();
            #1;
        end

        // Fill the FIFO behind continuous pipeline writes, starve it, then drain.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 5'd1, 32'(k), 1'b1, 5'(20 + k), 32'(32'h100 + k));
            step("fill");
        end
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b1, 5'd1, 32'(k), 1'b1, 5'd24, 32'h240);
            #2;
            if (k == 0) chk("full.lu_ready", 64'(lu_ready), 64'(0));
            step("starve");
        end
        got.delete();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
            #2;
            if (k == 0) begin
                chk("starve.stall_req", 64'(stall_req), 64'(1));
                chk("starve.q_count",   64'(q_count),   64'(4));
                chk("starve.lu_ready",  64'(lu_ready),  64'(0));
            end
            if (k == 1) chk("drain.stall_clear", 64'(stall_req), 64'(0));
            if (rf_we) got.push_back(rf_waddr);
            step("drain");
        end
        chk("drain.count", 64'(got.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk($sformatf("drain.order%0d", k), 64'(got[k]), 64'(20 + k));
        end

        // Reset with three entries queued: nothing may reach the regfile afterwards.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 5'd2, 32'h2, 1'b1, 5'(14 + k), 32'(32'hE0 + k));
            step("prerst");
        end
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        chk("rst.rf_we",     64'(rf_we),     64'(0));
        chk("rst.q_count",   64'(q_count),   64'(0));
        chk("rst.pend_mask", 64'(pend_mask), 64'(0));
        chk("rst.lu_ready",  64'(lu_ready),  64'(0));
        step("rst");
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
            #2;
            chk($sformatf("postrst%0d.rf_we", k),    64'(rf_we),    64'(0));
            chk($sformatf("postrst%0d.q_count", k),  64'(q_count),  64'(0));
            chk($sformatf("postrst%0d.lu_ready", k), 64'(lu_ready), 64'(1));
            step("postrst");
        end

`ifdef WAW_SQUASH_EN
        // Queued write to $5 is superseded by a newer pipeline write to $5.
        last5 = '0;
        drive(1'b0, 1'b1, 5'd1, 32'h0, 1'b1, 5'd5, 32'h1);
        step("waw0");
        drive(1'b0, 1'b1, 5'd5, 32'h2, 1'b0, '0, '0);
        #2;
        if (rf_we && rf_waddr == 5'd5) last5 = rf_wdata;
        step("waw1");
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        chk("waw.pend5",   64'(pend_mask[5]), 64'(0));
        chk("waw.rf_we",   64'(rf_we),        64'(0));
        chk("waw.q_count", 64'(q_count),      64'(1));
        if (rf_we && rf_waddr == 5'd5) last5 = rf_wdata;
        step("waw2");
        #2;
        chk("waw.q_empty", 64'(q_count), 64'(0));
        chk("waw.reg5",    64'(last5),   64'(32'h2));
        step("waw3");
`endif

        // Randomised traffic, alternating light, heavy and medium pipeline load.
        for (int c = 0; c < 1500; c++) begin
            wb_pct = ((c / 250) % 3 == 0) ? 20 : (((c / 250) % 3 == 1) ? 95 : 50);
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 99) < wb_pct,
                  5'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom());
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
